// File: rtl/stage2_round.sv
// Stage-2 block: 2-entry FIFO fed by stage-1 done pulses, ROUNDS key-dependent rotate/XOR
// rounds per word, valid/ready result port. Optional parity output under STAGE2_PARITY_EN.
module stage2_round #(
   parameter int ROUNDS = 4
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic [4:0]  key_bits,
   input  logic [15:0] stg1_in,
   input  logic        stg1_done,
   output logic        busy,
   output logic [15:0] stg2_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overrun
`ifdef STAGE2_PARITY_EN
   ,output logic       stg2_par
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_HOLD} state_t;

   localparam logic [3:0] W_LAST = 4'(ROUNDS - 1);

   state_t      r_state, w_next_state;
   logic [15:0] r_fifo [2];
   logic        r_wptr, r_rptr;
   logic [1:0]  r_cnt;
   logic [15:0] r_work;
   logic [4:0]  r_kr;
   logic [3:0]  r_rcnt;
   logic [15:0] r_out;
   logic        r_vld;
   logic        r_ovr;
   logic        r_par;

   logic        w_nempty, w_full;
   logic        w_push, w_drop;
   logic        w_pop, w_rnd, w_last, w_xfer, w_busy;
   logic [2:0]  w_amt;
   logic [31:0] w_dbl;
   logic [15:0] w_rot, w_round;

   assign w_nempty = (r_cnt != 2'd0);
   assign w_full   = (r_cnt == 2'd2);
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign w_push   = stg1_done && (!w_full || w_pop);
   assign w_drop   = stg1_done && w_full && !w_pop;

   // Round function: rotate left by kr[1:0]+1, then mix in key and round index.
   assign w_amt   = {1'b0, r_kr[1:0]} + 3'd1;
   assign w_dbl   = {r_work, r_work} << w_amt;
   assign w_rot   = w_dbl[31:16];
   assign w_round = w_rot ^ {11'd0, r_kr} ^ {12'd0, r_rcnt};

   always_ff @(posedge clk1) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_nempty) w_next_state = S_LOAD;
         S_LOAD:  w_next_state = S_ROUND;
         S_ROUND: if (r_rcnt == W_LAST) w_next_state = S_HOLD;
         S_HOLD:  if (out_ready) w_next_state = w_nempty ? S_LOAD : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop  = 1'b0;
      w_rnd  = 1'b0;
      w_last = 1'b0;
      w_xfer = 1'b0;
      w_busy = (r_state != S_IDLE);
      case (r_state)
         S_LOAD:  w_pop = 1'b1;
         S_ROUND: begin
            w_rnd  = 1'b1;
            w_last = (r_rcnt == W_LAST);
         end
         S_HOLD:  w_xfer = out_ready;
         default: ;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         r_fifo[0] <= '0;
         r_fifo[1] <= '0;
         r_wptr    <= 1'b0;
         r_rptr    <= 1'b0;
         r_cnt     <= 2'd0;
         r_ovr     <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= stg1_in;
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
         r_ovr <= w_drop;
      end
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         r_work <= '0;
         r_kr   <= '0;
         r_rcnt <= '0;
         r_out  <= '0;
         r_vld  <= 1'b0;
         r_par  <= 1'b0;
      end else begin
         if (w_pop) begin
            r_work <= r_fifo[r_rptr];
            r_kr   <= key_bits;
            r_rcnt <= '0;
         end else if (w_rnd) begin
            r_work <= w_round;
            // Counter parks on the last index so it never exceeds ROUNDS-1.
            if (!w_last) r_rcnt <= r_rcnt + 4'd1;
         end
         if (w_last) begin
            r_out <= w_round;
            r_par <= ^w_round;
            r_vld <= 1'b1;
         end else if (w_xfer) begin
            r_vld <= 1'b0;
         end
      end
   end

   assign busy      = w_busy;
   assign stg2_out  = r_out;
   assign out_valid = r_vld;
   assign overrun   = r_ovr;
`ifdef STAGE2_PARITY_EN
   assign stg2_par  = r_par;
`endif

endmodule

// File: tb/tb_stage2_round.sv
// Bench for stage2_round: directed cases plus randomized traffic scored against a
// transaction-level model (queue of buffered words, whole-word encode at load time).
module tb_stage2_round;

   localparam int R0 = 4;

   logic        clk1 = 1'b0;
   logic        rst;
   logic [4:0]  key_bits;
   logic [15:0] stg1_in;
   logic        stg1_done;
   logic        out_ready;
   logic        busy, out_valid, overrun;
   logic [15:0] stg2_out;
   logic        b1_busy, b1_valid, b1_ovr;
   logic [15:0] b1_out;
`ifdef STAGE2_PARITY_EN
   logic        stg2_par, b1_par;
`endif

   int n_chk = 0;
   int n_err = 0;

   stage2_round #(.ROUNDS(R0)) u0 (
      .clk1(clk1), .rst(rst), .key_bits(key_bits), .stg1_in(stg1_in), .stg1_done(stg1_done),
      .busy(busy), .stg2_out(stg2_out), .out_valid(out_valid), .out_ready(out_ready),
      .overrun(overrun)
`ifdef STAGE2_PARITY_EN
      , .stg2_par(stg2_par)
`endif
   );

   stage2_round #(.ROUNDS(1)) u1 (
      .clk1(clk1), .rst(rst), .key_bits(key_bits), .stg1_in(stg1_in), .stg1_done(stg1_done),
      .busy(b1_busy), .stg2_out(b1_out), .out_valid(b1_valid), .out_ready(out_ready),
      .overrun(b1_ovr)
`ifdef STAGE2_PARITY_EN
      , .stg2_par(b1_par)
`endif
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Whole-word reference: n rounds of rotl(k%4+1) ^ k ^ round index.
   function automatic logic [15:0] enc(input logic [15:0] w, input logic [4:0] k, input int n);
      logic [31:0] x;
      int a;
      a = int'(k[1:0]) + 1;
      for (int i = 0; i < n; i++) begin
         x = {16'd0, w} << a;
         w = x[15:0] | x[31:16];
         w = w ^ {11'd0, k} ^ 16'(i);
      end
      return w;
   endfunction

   // Model: m_ph 0 waiting, 1 loading, 2..R0+1 computing, R0+2 presenting.
   logic [15:0] m_q[$];
   int          m_ph = 0;
   logic [15:0] m_res = '0, m_out = '0;
   logic        m_vld = 1'b0, m_ovr = 1'b0, m_par = 1'b0;

   always @(posedge clk1) begin
      bit ne, pop;
      int sz;
      if (rst) begin
         m_q.delete();
         m_ph  = 0;
         m_out = '0;
         m_vld = 1'b0;
         m_ovr = 1'b0;
         m_par = 1'b0;
      end else begin
         ne  = (m_q.size() != 0);
         sz  = m_q.size();
         pop = (m_ph == 1);
         if (pop) m_res = enc(m_q.pop_front(), key_bits, R0);
         m_ovr = 1'b0;
         if (stg1_done) begin
            if (sz == 2 && !pop) m_ovr = 1'b1;
            else m_q.push_back(stg1_in);
         end
         if (m_ph == 0) begin
            if (ne) m_ph = 1;
         end else if (m_ph == 1) begin
            m_ph = 2;
         end else if (m_ph <= R0 + 1) begin
            if (m_ph == R0 + 1) begin
               m_out = m_res;
               m_par = ^m_res;
               m_vld = 1'b1;
            end
            m_ph = m_ph + 1;
         end else if (out_ready) begin
            m_vld = 1'b0;
            m_ph  = ne ? 1 : 0;
         end
      end
   end

   task automatic cmp_all();
      chk("valid",   16'(out_valid), 16'(m_vld));
      chk("busy",    16'(busy),      16'(m_ph != 0));
      chk("overrun", 16'(overrun),   16'(m_ovr));
      chk("out",     stg2_out,       m_out);
`ifdef STAGE2_PARITY_EN
      chk("par",     16'(stg2_par),  16'(m_par));
`endif
   endtask

   task automatic tick();
      @(negedge clk1);
      cmp_all();
   endtask

   task automatic push(input logic [15:0] w);
      stg1_in   = w;
      stg1_done = 1'b1;
      tick();
      stg1_done = 1'b0;
   endtask

   initial begin
      int n;
      logic [15:0] got[$];
      logic [15:0] wa, wb, wc, wd;
      bit seen;

      rst = 1'b1; key_bits = '0; stg1_in = '0; stg1_done = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_valid", 16'(out_valid), 16'd0);
      chk("rst_busy",  16'(busy),      16'd0);
      chk("rst_out",   stg2_out,       16'd0);
      chk("rst_ovr",   16'(overrun),   16'd0);
      rst = 1'b0;
      tick();

      // Latency and known vector, key 0.
      push(16'h8001);
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("latency", 16'(n), 16'(R0 + 2));
      chk("vec_8001", stg2_out, 16'h001B);
      chk("r1_8001", b1_out, 16'h0003);
`ifdef STAGE2_PARITY_EN
      chk("par_001B", 16'(stg2_par), 16'd0);
`endif
      // Stall in HOLD, then a single transfer.
      repeat (10) begin
         tick();
         chk("hold_vld", 16'(out_valid), 16'd1);
         chk("hold_out", stg2_out, 16'h001B);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("xfer_vld", 16'(out_valid), 16'd0);
      chk("xfer_keep", stg2_out, 16'h001B);
      tick();

      // ROUNDS=1 vector, key 3.
      key_bits = 5'b00011;
      push(16'h0001);
      n = 0;
      while (!b1_valid && n < 20) begin tick(); n++; end
      chk("r1_latency", 16'(n), 16'd3);
      chk("r1_0001", b1_out, 16'h0013);
`ifdef STAGE2_PARITY_EN
      chk("par_0013", 16'(b1_par), 16'd1);
`endif
      out_ready = 1'b1;
      n = 0;
      while ((busy || out_valid) && n < 30) begin tick(); n++; end
      chk("drain1", 16'(busy || out_valid), 16'd0);
      out_ready = 1'b0;

      // Overrun: three pushes while a job sits in the engine.
      key_bits = 5'h16;
      wa = 16'h1234; wb = 16'hBEEF; wc = 16'h0F0F; wd = 16'hA5A5;
      push(wa);
      tick(); tick();
      push(wb);
      chk("ovr_b", 16'(overrun), 16'd0);
      push(wc);
      chk("ovr_c", 16'(overrun), 16'd0);
      push(wd);
      chk("ovr_d", 16'(overrun), 16'd1);
      tick();
      chk("ovr_pulse", 16'(overrun), 16'd0);
      out_ready = 1'b1;
      n = 0;
      while (n < 60) begin
         if (out_valid) got.push_back(stg2_out);
         tick(); n++;
      end
      out_ready = 1'b0;
      chk("ovr_count", 16'(got.size()), 16'd3);
      if (got.size() == 3) begin
         chk("ovr_w0", got[0], enc(wa, 5'h16, R0));
         chk("ovr_w1", got[1], enc(wb, 5'h16, R0));
         chk("ovr_w2", got[2], enc(wc, 5'h16, R0));
      end

      // Reset in the middle of a job with one word buffered.
      push(16'h7777);
      tick(); tick();
      push(16'h3333);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_vld",  16'(out_valid), 16'd0);
      chk("mrst_busy", 16'(busy),      16'd0);
      chk("mrst_out",  stg2_out,       16'd0);
      seen = 1'b0;
      repeat (15) begin
         tick();
         if (out_valid || busy) seen = 1'b1;
      end
      chk("mrst_quiet", 16'(seen), 16'd0);

      // Randomized traffic; key churns every cycle to exercise the load-time latch.
      for (int c = 0; c < 3000; c++) begin
         stg1_done = ($urandom_range(2) == 0);
         stg1_in   = 16'($urandom);
         key_bits  = 5'($urandom);
         out_ready = ($urandom_range(1) == 0);
         rst       = ($urandom_range(299) == 0);
         tick();
      end
      stg1_done = 1'b0; rst = 1'b0; out_ready = 1'b1;
      repeat (40) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
